iq_vector_packer: RTL and testbench
===================================

Name: iq_vector_packer

Overview:
- Streaming producer for the dot-product datapath. Accepts one complex x sample and one complex y sample per handshake.
- Packs LENGTH consecutive sample pairs into the wide signed xi/xq/yi/yq vectors the dot-product unit consumes, and presents them with a valid/ready handshake.
- Double-buffered: an output holding register plus a fill buffer, so that input streaming sustains one sample per cycle while the consumer accepts without stalls.

Parameters:
- LENGTH, 8, samples per packed vector; LENGTH >= 2.
- XI_BITS, 12, width of one x in-phase sample.
- XQ_BITS, 12, width of one x quadrature sample.
- YI_BITS, 12, width of one y in-phase sample.
- YQ_BITS, 12, width of one y quadrature sample.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input sample pair valid.
- s_axis_tready  out  1  packer can accept a sample pair.
- s_axis_tlast  in  1  last sample of a burst; closes the vector early.
- s_xi  in  XI_BITS  signed x in-phase sample.
- s_xq  in  XQ_BITS  signed x quadrature sample.
- s_yi  in  YI_BITS  signed y in-phase sample.
- s_yq  in  YQ_BITS  signed y quadrature sample.
- m_axis_tvalid  out  1  packed vector valid.
- m_axis_tready  in  1  consumer accepts the vector.
- m_axis_tlast  out  1  vector was closed by s_axis_tlast.
- m_xi  out  XI_BITS*LENGTH  packed x in-phase vector.
- m_xq  out  XQ_BITS*LENGTH  packed x quadrature vector.
- m_yi  out  YI_BITS*LENGTH  packed y in-phase vector.
- m_yq  out  YQ_BITS*LENGTH  packed y quadrature vector.

Behaviour:
- Reset (async, immediate): fill count = 0, fill buffer = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_* vectors = 0.
  - s_axis_tready is 1 from the first clock edge after reset deasserts.
  - Reset mid-vector discards partial data; nothing is emitted.
- Packing order: the k-th accepted sample of a vector (k = 0..LENGTH-1) occupies bits [(k+1)*W-1 : k*W] of each vector. Sample 0 is in the LSBs.
- Accept condition: s_axis_tvalid && s_axis_tready.
- Output slot free: !m_axis_tvalid || m_axis_tready.
- Fill count cnt ranges 0..LENGTH. cnt == LENGTH means a complete vector is parked in the fill buffer.
- s_axis_tready = (cnt != LENGTH). It is a pure function of registered state, with no combinational path from m_axis_tready.
- Accept with cnt < LENGTH-1 and s_axis_tlast = 0: write the sample to slot cnt; cnt += 1.
- Closing accept (cnt == LENGTH-1, or s_axis_tlast = 1 at any cnt):
  - Form a vector from the existing slots plus the new sample in slot cnt.
  - All higher slots are zero-padded.
  - Closing flag = s_axis_tlast.
  - If the slot is free: load the output registers, set m_axis_tvalid = 1 and m_axis_tlast = flag on the next cycle, and set cnt = 0. Latency from the closing accept to m_axis_tvalid is 1 cycle.
  - If the slot is not free: park the vector and flag in the fill buffer; cnt = LENGTH.
- Parked vector (cnt == LENGTH) and slot free: move it to the output registers, set m_axis_tvalid = 1, set cnt = 0, and clear the fill buffer to 0.
- After any close, the fill buffer slots read 0 for the next vector.
- Output handshake:
  - While m_axis_tvalid = 1 && !m_axis_tready, all m_* outputs hold stable.
  - On accept with no new vector ready, m_axis_tvalid goes 0 next cycle.
  - Simultaneous output accept and closing input accept: the new vector loads directly, m_axis_tvalid stays 1, giving back-to-back vectors with no bubble.
- Sustained throughput: one vector per LENGTH cycles with m_axis_tready held high.
- Backpressure: at most 2 complete vectors are held (output + parked). Input stalls only when both are occupied.
- s_axis_tlast on the first sample (cnt == 0): emits a vector with only slot 0 populated.
- m_axis_tlast is qualified by m_axis_tvalid.
- No arithmetic is performed. Samples are copied bit-exact, and sign is preserved by the consumer's signed declarations.

Test Plan:
- Reset, then 8 pairs (xi = xq = yi = yq = k, k = 0..7) with m_axis_tready = 1 → one cycle after the 8th accept, m_axis_tvalid = 1; m_xi slot k = k; m_axis_tlast = 0; valid for exactly 1 cycle.
- 24 continuous pairs with m_axis_tready = 1 → 3 vectors on cycles 9, 17, 25 after the first accept; s_axis_tready never drops.
- m_axis_tready = 0 throughout, 24 pairs offered → two vectors held; s_axis_tready drops after the 16th accept. Raising m_axis_tready yields vector 0, vector 1 on consecutive cycles, then input resumes.
- 3 pairs with values -1, -2048, 2047, the third with s_axis_tlast = 1 → m_xi slots 0..2 = 0xFFF, 0x800, 0x7FF; slots 3..7 = 0; m_axis_tlast = 1.
- Assert rst after 5 accepted samples, then 8 fresh pairs → first vector contains only the fresh samples; all outputs read 0 during reset.
- m_axis_tready toggling 1/0 every cycle with random values → outputs stable while stalled; no sample lost or duplicated versus the scoreboard.

Source files
------------

// File: rtl/iq_vector_packer_if.sv
// Sample-pair input stream and packed-vector output stream of iq_vector_packer.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1; a source holds valid and payload stable until that edge.
interface iq_vector_packer_if #(
    parameter int LENGTH  = 8,
    parameter int XI_BITS = 12,
    parameter int XQ_BITS = 12,
    parameter int YI_BITS = 12,
    parameter int YQ_BITS = 12
);
    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic                        s_axis_tlast;
    logic [XI_BITS-1:0]          s_xi;
    logic [XQ_BITS-1:0]          s_xq;
    logic [YI_BITS-1:0]          s_yi;
    logic [YQ_BITS-1:0]          s_yq;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic                        m_axis_tlast;
    logic [XI_BITS*LENGTH-1:0]   m_xi;
    logic [XQ_BITS*LENGTH-1:0]   m_xq;
    logic [YI_BITS*LENGTH-1:0]   m_yi;
    logic [YQ_BITS*LENGTH-1:0]   m_yq;

    modport slave (
        input  s_axis_tvalid, s_axis_tlast, s_xi, s_xq, s_yi, s_yq, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tlast, m_xi, m_xq, m_yi, m_yq
    );

    modport master (
        output s_axis_tvalid, s_axis_tlast, s_xi, s_xq, s_yi, s_yq, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_xi, m_xq, m_yi, m_yq
    );
endinterface

// File: rtl/iq_vector_packer.sv
// Packs LENGTH complex x/y sample pairs into wide vectors; an output register plus a
// parking fill buffer let input stream at one pair per cycle under consumer backpressure.
module iq_vector_packer #(
    parameter int LENGTH  = 8,
    parameter int XI_BITS = 12,
    parameter int XQ_BITS = 12,
    parameter int YI_BITS = 12,
    parameter int YQ_BITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    iq_vector_packer_if.slave bus
);
    localparam int CW = $clog2(LENGTH + 1);
    localparam int XIW = XI_BITS * LENGTH;
    localparam int XQW = XQ_BITS * LENGTH;
    localparam int YIW = YI_BITS * LENGTH;
    localparam int YQW = YQ_BITS * LENGTH;
    localparam logic [CW-1:0] FULL      = CW'(LENGTH);
    localparam logic [CW-1:0] LAST_SLOT = CW'(LENGTH - 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           live_q;
    logic [XIW-1:0] xi_buf_q, xi_buf_d, xi_out_q, xi_out_d, xi_vec;
    logic [XQW-1:0] xq_buf_q, xq_buf_d, xq_out_q, xq_out_d, xq_vec;
    logic [YIW-1:0] yi_buf_q, yi_buf_d, yi_out_q, yi_out_d, yi_vec;
    logic [YQW-1:0] yq_buf_q, yq_buf_d, yq_out_q, yq_out_d, yq_vec;
    logic           park_last_q, park_last_d;
    logic           m_valid_q, m_valid_d;
    logic           m_last_q, m_last_d;

    logic s_ready, s_acc, slot_free, closing;

    // live_q keeps s_axis_tready low until the first edge after reset releases.
    assign s_ready   = live_q && (cnt_q != FULL);
    assign s_acc     = bus.s_axis_tvalid && s_ready;
    assign slot_free = !m_valid_q || bus.m_axis_tready;
    assign closing   = s_acc && (bus.s_axis_tlast || (cnt_q == LAST_SLOT));

    // Higher slots of the fill buffer are always zero, so dropping the new sample
    // into slot cnt yields a correctly zero-padded vector.
    always_comb begin
        xi_vec = xi_buf_q;
        xq_vec = xq_buf_q;
        yi_vec = yi_buf_q;
        yq_vec = yq_buf_q;
        if (cnt_q != FULL) begin
            xi_vec[cnt_q*XI_BITS +: XI_BITS] = bus.s_xi;
            xq_vec[cnt_q*XQ_BITS +: XQ_BITS] = bus.s_xq;
            yi_vec[cnt_q*YI_BITS +: YI_BITS] = bus.s_yi;
            yq_vec[cnt_q*YQ_BITS +: YQ_BITS] = bus.s_yq;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        xi_buf_d    = xi_buf_q;
        xq_buf_d    = xq_buf_q;
        yi_buf_d    = yi_buf_q;
        yq_buf_d    = yq_buf_q;
        park_last_d = park_last_q;
        xi_out_d    = xi_out_q;
        xq_out_d    = xq_out_q;
        yi_out_d    = yi_out_q;
        yq_out_d    = yq_out_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;

        if (m_valid_q && bus.m_axis_tready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if ((cnt_q == FULL) && slot_free) begin
            xi_out_d    = xi_buf_q;
            xq_out_d    = xq_buf_q;
            yi_out_d    = yi_buf_q;
            yq_out_d    = yq_buf_q;
            m_last_d    = park_last_q;
            m_valid_d   = 1'b1;
            cnt_d       = '0;
            xi_buf_d    = '0;
            xq_buf_d    = '0;
            yi_buf_d    = '0;
            yq_buf_d    = '0;
            park_last_d = 1'b0;
        end else if (closing && slot_free) begin
            xi_out_d  = xi_vec;
            xq_out_d  = xq_vec;
            yi_out_d  = yi_vec;
            yq_out_d  = yq_vec;
            m_last_d  = bus.s_axis_tlast;
            m_valid_d = 1'b1;
            cnt_d     = '0;
            xi_buf_d  = '0;
            xq_buf_d  = '0;
            yi_buf_d  = '0;
            yq_buf_d  = '0;
        end else if (closing) begin
            xi_buf_d    = xi_vec;
            xq_buf_d    = xq_vec;
            yi_buf_d    = yi_vec;
            yq_buf_d    = yq_vec;
            park_last_d = bus.s_axis_tlast;
            cnt_d       = FULL;
        end else if (s_acc) begin
            xi_buf_d = xi_vec;
            xq_buf_d = xq_vec;
            yi_buf_d = yi_vec;
            yq_buf_d = yq_vec;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            live_q      <= 1'b0;
            xi_buf_q    <= '0;
            xq_buf_q    <= '0;
            yi_buf_q    <= '0;
            yq_buf_q    <= '0;
            park_last_q <= 1'b0;
            xi_out_q    <= '0;
            xq_out_q    <= '0;
            yi_out_q    <= '0;
            yq_out_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            live_q      <= 1'b1;
            xi_buf_q    <= xi_buf_d;
            xq_buf_q    <= xq_buf_d;
            yi_buf_q    <= yi_buf_d;
            yq_buf_q    <= yq_buf_d;
            park_last_q <= park_last_d;
            xi_out_q    <= xi_out_d;
            xq_out_q    <= xq_out_d;
            yi_out_q    <= yi_out_d;
            yq_out_q    <= yq_out_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
        end
    end

    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign bus.m_xi          = xi_out_q;
    assign bus.m_xq          = xq_out_q;
    assign bus.m_yi          = yi_out_q;
    assign bus.m_yq          = yq_out_q;
endmodule

// File: tb/tb_iq_vector_packer.sv
// Directed and randomized checks of iq_vector_packer against a queue-based model of
// vector formation (chunks of LENGTH samples, closed early by tlast, zero-padded).
module tb_iq_vector_packer;
    localparam int L  = 8;
    localparam int W  = 12;
    localparam int VW = W * L;
    localparam int EW = 4 * VW + 1;

    typedef logic [4*W-1:0] samp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    samp_t         part_q[$];
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] prev_out;
    bit            prev_stall = 0;
    bit            done6 = 0;

    iq_vector_packer_if #(.LENGTH(L), .XI_BITS(W), .XQ_BITS(W), .YI_BITS(W), .YQ_BITS(W)) bus ();

    iq_vector_packer #(.LENGTH(L), .XI_BITS(W), .XQ_BITS(W), .YI_BITS(W), .YQ_BITS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack_vec(input bit last);
        logic [VW-1:0] vxi = '0, vxq = '0, vyi = '0, vyq = '0;
        for (int k = 0; k < part_q.size(); k++) begin
            vxi[k*W +: W] = part_q[k][W-1:0];
            vxq[k*W +: W] = part_q[k][2*W-1:W];
            vyi[k*W +: W] = part_q[k][3*W-1:2*W];
            vyq[k*W +: W] = part_q[k][4*W-1:3*W];
        end
        return {last, vyq, vyi, vxq, vxi};
    endfunction

    function automatic logic [EW-1:0] out_now();
        return {bus.m_axis_tlast, bus.m_yq, bus.m_yi, bus.m_xq, bus.m_xi};
    endfunction

    // Scoreboard: model input accepts and check every output transfer and stall.
    always @(negedge clk) begin
        if (rst) begin
            part_q.delete();
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", bus.m_axis_tvalid, 1'b1);
                chk("stall_hold", out_now(), prev_out);
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (exp_q.size() == 0) chk("unexpected_vec", 1'b1, 1'b0);
                else chk("vector", out_now(), exp_q.pop_front());
            end
            prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_out   = out_now();
            if (bus.s_axis_tvalid && bus.s_axis_tready) begin
                part_q.push_back({bus.s_yq, bus.s_yi, bus.s_xq, bus.s_xi});
                if (bus.s_axis_tlast || part_q.size() == L) begin
                    exp_q.push_back(pack_vec(bus.s_axis_tlast));
                    part_q.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] xi, xq, yi, yq, input logic last, output int waits);
        bit got = 0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = last;
        bus.s_xi = xi;
        bus.s_xq = xq;
        bus.s_yi = yi;
        bus.s_yq = yq;
        waits = 0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (bus.s_axis_tready === 1'b1) got = 1;
            else waits++;
        end
        tick();
        if (!got) chk("send_timeout", got, 1'b1);
    endtask

    task automatic send_rand(input logic last, output int waits);
        send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), last, waits);
    endtask

    task automatic idle(input int n);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"}, out_now(), '0);
        chk({tag, "_valid"}, bus.m_axis_tvalid, 1'b0);
        chk({tag, "_ready"}, bus.s_axis_tready, 1'b0);
    endtask

    initial begin
        int w;
        int n;
        logic [VW-1:0] ev;
        logic [W-1:0]  fresh[L];

        rst = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_xi = '0;
        bus.s_xq = '0;
        bus.s_yi = '0;
        bus.s_yq = '0;
        bus.m_axis_tready = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("ready_after_reset", bus.s_axis_tready, 1'b1);

        // 1: one full vector of ramp values, valid for exactly one cycle.
        bus.m_axis_tready = 1'b1;
        ev = '0;
        for (int k = 0; k < L; k++) begin
            send(W'(k), W'(k), W'(k), W'(k), 1'b0, w);
            ev[k*W +: W] = W'(k);
            chk("t1_valid", bus.m_axis_tvalid, (k == L - 1));
        end
        chk("t1_xi", bus.m_xi, ev);
        chk("t1_yq", bus.m_yq, ev);
        chk("t1_last", bus.m_axis_tlast, 1'b0);
        idle(1);
        chk("t1_one_cycle", bus.m_axis_tvalid, 1'b0);
        idle(2);

        // 2: three back-to-back vectors, input never stalls.
        for (int i = 0; i < 3 * L; i++) begin
            send_rand(1'b0, w);
            chk("t2_no_stall", w, 0);
            chk("t2_valid", bus.m_axis_tvalid, (i % L == L - 1));
        end
        idle(2);

        // 3: consumer blocked: two vectors held, then drained on consecutive cycles.
        bus.m_axis_tready = 1'b0;
        n = 0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = 1'b0;
        bus.s_xi = W'($urandom);
        for (int c = 0; c < 3 * L + 6; c++) begin
            @(negedge clk);
            if (bus.s_axis_tready) n++;
            tick();
            bus.s_xi = W'($urandom);
            bus.s_yq = W'($urandom);
        end
        chk("t3_accepted", n, 2 * L);
        chk("t3_ready_low", bus.s_axis_tready, 1'b0);
        chk("t3_valid_held", bus.m_axis_tvalid, 1'b1);
        bus.m_axis_tready = 1'b1;
        @(negedge clk);
        chk("t3_vec0_valid", bus.m_axis_tvalid, 1'b1);
        chk("t3_vec0_ready", bus.s_axis_tready, 1'b0);
        tick();
        chk("t3_vec1_valid", bus.m_axis_tvalid, 1'b1);
        chk("t3_resume", bus.s_axis_tready, 1'b1);
        for (int i = 0; i < L; i++) send_rand(1'b0, w);
        chk("t3_vec2_valid", bus.m_axis_tvalid, 1'b1);
        idle(3);

        // 4: early close by tlast with signed extremes, zero padding above.
        send(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0, w);
        send(12'h800, 12'h800, 12'h800, 12'h800, 1'b0, w);
        send(12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 1'b1, w);
        ev = '0;
        ev[W-1:0]     = 12'hFFF;
        ev[2*W-1:W]   = 12'h800;
        ev[3*W-1:2*W] = 12'h7FF;
        chk("t4_valid", bus.m_axis_tvalid, 1'b1);
        chk("t4_last", bus.m_axis_tlast, 1'b1);
        chk("t4_xi", bus.m_xi, ev);
        chk("t4_yi", bus.m_yi, ev);
        idle(3);

        // 5: reset mid-vector discards the partial samples.
        for (int i = 0; i < 5; i++) send_rand(1'b0, w);
        bus.s_axis_tvalid = 1'b0;
        rst = 1'b1;
        #2;
        chk_all_zero("t5_reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        ev = '0;
        for (int k = 0; k < L; k++) begin
            fresh[k] = W'($urandom);
            ev[k*W +: W] = fresh[k];
            send(fresh[k], fresh[k], fresh[k], fresh[k], 1'b0, w);
        end
        chk("t5_valid", bus.m_axis_tvalid, 1'b1);
        chk("t5_xi", bus.m_xi, ev);
        chk("t5_last", bus.m_axis_tlast, 1'b0);
        idle(3);

        // 6: random stream, random tlast and gaps, consumer toggling every cycle.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send_rand(($urandom_range(0, 9) == 0) || (i == 149), w);
                end
                done6 = 1;
            end
            begin
                while (!done6) begin
                    tick();
                    bus.m_axis_tready = ~bus.m_axis_tready;
                end
            end
        join
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        for (int t = 0; t < 20 && (exp_q.size() != 0 || bus.m_axis_tvalid); t++) tick();
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_no_partial", part_q.size(), 0);
        chk("t6_idle", bus.m_axis_tvalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
